// File: rtl/l2_req_arbiter_pkg.sv
// Shared types for the L2 request arbiter.
// Line, address and FSM state definitions.
package l2_req_arbiter_pkg;

  localparam int PADDR_W = 56;
  localparam int LINE_W  = 512;

  typedef logic [PADDR_W-1:0] paddr_t;
  typedef logic [LINE_W-1:0]  cacheline_t;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RETURN
  } arb_state_t;

  localparam int REQ_L1I = 0;
  localparam int REQ_L1D = 1;
  localparam int REQ_PTW = 2;

endpackage

// File: rtl/l2_req_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request at or above ptr.
// Pure combinational, shared with the L2 bank arbiters.
module rr_priority_picker #(
  parameter int N = 3,
  parameter int B = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [B-1:0] i_ptr,
  output logic [B-1:0] o_winner,
  output logic         o_found
);

  logic [B:0]   sum;
  logic [B-1:0] idx;

  // scan N slots starting at the pointer, wrapping modulo N
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, i_ptr} + (B+1)'(i);
      if (sum >= (B+1)'(N)) sum = sum - (B+1)'(N);
      idx = sum[B-1:0];
      if (!o_found && i_req[idx]) begin
        o_found  = 1'b1;
        o_winner = idx;
      end
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Single-port L2 request arbiter for L1I, L1D and PTW.
// One miss in flight, round-robin grant, watchdog return.
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int REQ_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_BITS   = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  paddr_t             i_req_paddr [NUM_REQ],
  output logic [NUM_REQ-1:0] o_returned,
  output cacheline_t         o_ret_data,
  output logic               o_ret_error,
  output logic               o_l2_req,
  input  logic               i_l2_grant,
  output logic               o_l2_req_valid,
  output paddr_t             o_l2_req_paddr,
  input  logic               i_l2_returned,
  input  cacheline_t         i_l2_returned_data,
  output logic               o_timeout_sticky
);

  arb_state_t              state_q, state_d;
  logic [REQ_BITS-1:0]     rr_q, rr_d;
  logic [REQ_BITS-1:0]     owner_q, owner_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic [NUM_REQ-1:0]      grant_d, ret_d;
  cacheline_t              data_d;
  logic                    err_d, l2_req_d;
  logic                    l2_vld_d, sticky_d;
  paddr_t                  paddr_d;

  logic [REQ_BITS-1:0]     winner;
  logic                    found;
  logic [NUM_REQ-1:0]      owner_oh;
  logic                    wd_expired;

  rr_priority_picker #(
    .N (NUM_REQ),
    .B (REQ_BITS)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (rr_q),
    .o_winner (winner),
    .o_found  (found)
  );

  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign wd_expired =
    wd_q == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  // next state; pulses default low, held outputs default to hold
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    wd_d     = wd_q;
    grant_d  = o_grant;
    ret_d    = '0;
    data_d   = '0;
    err_d    = 1'b0;
    l2_req_d = o_l2_req;
    l2_vld_d = 1'b0;
    paddr_d  = o_l2_req_paddr;
    sticky_d = o_timeout_sticky;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          owner_d = winner;
          grant_d = NUM_REQ'(1) << winner;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (i_req_valid[owner_q]) begin
          paddr_d  = i_req_paddr[owner_q];
          grant_d  = '0;
          l2_req_d = 1'b1;
          state_d  = ARB_ISSUE;
        end else if (!i_req[owner_q]) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (i_l2_grant) begin
          l2_req_d = 1'b0;
          l2_vld_d = 1'b1;
          state_d  = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (i_l2_returned) begin
          ret_d   = owner_oh;
          data_d  = i_l2_returned_data;
          state_d = ARB_RETURN;
        end else if (wd_expired) begin
          ret_d    = owner_oh;
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = ARB_RETURN;
        end else begin
          wd_d = wd_q + TIMEOUT_BITS'(1);
        end
      end
      ARB_RETURN: begin
        rr_d = (owner_q == REQ_BITS'(NUM_REQ - 1))
             ? '0 : owner_q + REQ_BITS'(1);
        wd_d    = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // state and registered outputs; reset drops any transaction
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= ARB_IDLE;
      rr_q             <= '0;
      owner_q          <= '0;
      wd_q             <= '0;
      o_grant          <= '0;
      o_returned       <= '0;
      o_ret_data       <= '0;
      o_ret_error      <= 1'b0;
      o_l2_req         <= 1'b0;
      o_l2_req_valid   <= 1'b0;
      o_l2_req_paddr   <= '0;
      o_timeout_sticky <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_q             <= rr_d;
      owner_q          <= owner_d;
      wd_q             <= wd_d;
      o_grant          <= grant_d;
      o_returned       <= ret_d;
      o_ret_data       <= data_d;
      o_ret_error      <= err_d;
      o_l2_req         <= l2_req_d;
      o_l2_req_valid   <= l2_vld_d;
      o_l2_req_paddr   <= paddr_d;
      o_timeout_sticky <= sticky_d;
    end
  end

  a_grant_oh: assert property (
    @(posedge i_clk) disable iff (i_rst)
    $onehot0(o_grant));

  a_ret_oh: assert property (
    @(posedge i_clk) disable iff (i_rst)
    $onehot0(o_returned));

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter.
// Vector table plus multi-cycle corner sequences.
module tb_l2_req_arbiter;
  import l2_req_arbiter_pkg::*;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] vld = '0;
  paddr_t       paddr [N];
  logic         l2g = 1'b0;
  logic         l2r = 1'b0;
  cacheline_t   l2d = '0;

  logic [N-1:0] grant, ret;
  cacheline_t   ret_data;
  logic         ret_err, l2req, l2vld, sticky;
  paddr_t       l2paddr;

  int n_chk = 0;
  int n_pass = 0;

  l2_req_arbiter #(
    .NUM_REQ        (N),
    .REQ_BITS       (2),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_BITS   (5)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_req              (req),
    .o_grant            (grant),
    .i_req_valid        (vld),
    .i_req_paddr        (paddr),
    .o_returned         (ret),
    .o_ret_data         (ret_data),
    .o_ret_error        (ret_err),
    .o_l2_req           (l2req),
    .i_l2_grant         (l2g),
    .o_l2_req_valid     (l2vld),
    .o_l2_req_paddr     (l2paddr),
    .i_l2_returned      (l2r),
    .i_l2_returned_data (l2d),
    .o_timeout_sticky   (sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] vld;
    logic         l2g;
    logic         l2r;
    logic [N-1:0] grant;
    logic         l2req;
    logic         l2vld;
    logic [N-1:0] ret;
  } vec_t;

  vec_t vecs [16];

  localparam cacheline_t LINE_A = {64{8'hA5}};
  localparam paddr_t     PA0    = 56'h8000_1000;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic chk_line(input string nm,
                          input cacheline_t act,
                          input cacheline_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    vld = '0;
    l2g = 1'b0;
    l2r = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic [N-1:0] rq, input logic [N-1:0] vl,
    input logic g, input logic r,
    input logic [N-1:0] eg, input logic elr,
    input logic elv, input logic [N-1:0] er);
    vec_t v;
    v.req = rq; v.vld = vl; v.l2g = g; v.l2r = r;
    v.grant = eg; v.l2req = elr; v.l2vld = elv;
    v.ret = er;
    return v;
  endfunction

  task automatic to_wait(input int w);
    logic [N-1:0] oh;
    oh  = N'(1) << w;
    req = oh;
    step();
    chk("tw_grant", 64'(grant), 64'(oh));
    vld = oh;
    step();
    vld = '0;
    req = '0;
    l2g = 1'b1;
    step();
    l2g = 1'b0;
  endtask

  initial begin
    paddr[0] = PA0;
    paddr[1] = 56'h0000_2000;
    paddr[2] = 56'h0000_3000;

    vecs[0]  = mk(3'b001, 3'b000, 0, 0, 3'b001, 0, 0, 3'b000);
    vecs[1]  = mk(3'b001, 3'b001, 0, 0, 3'b000, 1, 0, 3'b000);
    vecs[2]  = mk(3'b000, 3'b000, 1, 0, 3'b000, 0, 1, 3'b000);
    vecs[3]  = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[4]  = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[5]  = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[6]  = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[7]  = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[8]  = mk(3'b000, 3'b000, 0, 1, 3'b000, 0, 0, 3'b001);
    vecs[9]  = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[10] = mk(3'b011, 3'b000, 0, 0, 3'b010, 0, 0, 3'b000);
    vecs[11] = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[12] = mk(3'b011, 3'b000, 0, 0, 3'b010, 0, 0, 3'b000);
    vecs[13] = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);
    vecs[14] = mk(3'b100, 3'b000, 0, 0, 3'b100, 0, 0, 3'b000);
    vecs[15] = mk(3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000);

    // reset values while reset is held
    step();
    chk("rst_grant", 64'(grant), 0);
    chk("rst_l2req", 64'(l2req), 0);
    chk("rst_paddr", 64'(l2paddr), 0);
    chk_line("rst_data", ret_data, '0);
    rst = 1'b0;

    // single L1I miss, rr advance, abandon
    l2d = LINE_A;
    for (int i = 0; i < 16; i++) begin
      req = vecs[i].req;
      vld = vecs[i].vld;
      l2g = vecs[i].l2g;
      l2r = vecs[i].l2r;
      step();
      chk($sformatf("v%0d_grant", i),
          64'(grant), 64'(vecs[i].grant));
      chk($sformatf("v%0d_l2req", i),
          64'(l2req), 64'(vecs[i].l2req));
      chk($sformatf("v%0d_l2vld", i),
          64'(l2vld), 64'(vecs[i].l2vld));
      chk($sformatf("v%0d_ret", i),
          64'(ret), 64'(vecs[i].ret));
      chk($sformatf("v%0d_err", i), 64'(ret_err), 0);
      chk_line($sformatf("v%0d_data", i), ret_data,
               (vecs[i].ret != 0) ? LINE_A : '0);
      if (vecs[i].l2vld)
        chk($sformatf("v%0d_paddr", i),
            64'(l2paddr), 64'(PA0));
    end
    l2r = 1'b0;

    // fairness with all three requesting
    do_reset();
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      logic [N-1:0] oh;
      cacheline_t   ln;
      oh = N'(1) << (n % 3);
      ln = {16{32'(n + 1)}};
      step();
      chk($sformatf("rr%0d_grant", n),
          64'(grant), 64'(oh));
      vld = oh;
      step();
      chk($sformatf("rr%0d_l2req", n), 64'(l2req), 1);
      vld = '0;
      l2g = 1'b1;
      step();
      chk($sformatf("rr%0d_l2vld", n), 64'(l2vld), 1);
      chk($sformatf("rr%0d_paddr", n), 64'(l2paddr),
          64'(paddr[n % 3]));
      l2g = 1'b0;
      l2r = 1'b1;
      l2d = ln;
      step();
      chk($sformatf("rr%0d_ret", n), 64'(ret), 64'(oh));
      chk_line($sformatf("rr%0d_data", n), ret_data, ln);
      l2r = 1'b0;
      step();
      chk($sformatf("rr%0d_clr", n), 64'(ret), 0);
    end
    req = '0;
    step();

    // watchdog timeout, no L2 response
    begin
      int seen;
      seen = 0;
      to_wait(REQ_PTW);
      for (int k = 1; k <= 40; k++) begin
        step();
        if (ret != 0) begin
          seen = k;
          break;
        end
      end
      chk("to_latency", 64'(seen), 16);
      chk("to_ret", 64'(ret), 64'(3'b100));
      chk("to_err", 64'(ret_err), 1);
      chk_line("to_data", ret_data, '0);
      chk("to_sticky", 64'(sticky), 1);
      step();
      l2r = 1'b1;
      step();
      l2r = 1'b0;
      chk("to_stray_ret", 64'(ret), 0);
      step();
      chk("to_sticky_hold", 64'(sticky), 1);
    end

    // asynchronous reset while waiting on L2
    to_wait(REQ_L1D);
    chk("rw_paddr_pre", 64'(l2paddr), 64'(paddr[1]));
    rst = 1'b1;
    #1;
    chk("rw_paddr", 64'(l2paddr), 0);
    chk("rw_sticky", 64'(sticky), 0);
    chk("rw_grant", 64'(grant), 0);
    chk("rw_l2req", 64'(l2req), 0);
    step();
    rst = 1'b0;
    req = 3'b010;
    step();
    chk("rw_regrant", 64'(grant), 64'(3'b010));
    req = '0;
    step();

    // response and timeout on the same cycle
    to_wait(REQ_L1I);
    repeat (15) step();
    chk("tie_pre_ret", 64'(ret), 0);
    l2r = 1'b1;
    l2d = LINE_A;
    step();
    l2r = 1'b0;
    chk("tie_ret", 64'(ret), 64'(3'b001));
    chk("tie_err", 64'(ret_err), 0);
    chk_line("tie_data", ret_data, LINE_A);
    chk("tie_sticky", 64'(sticky), 0);
    step();
    chk_line("tie_data_clr", ret_data, '0);
    l2r = 1'b1;
    step();
    l2r = 1'b0;
    chk("idle_stray_ret", 64'(ret), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
